ps2_device_transceiver: RTL and testbench



---
 rtl/ps2_dev_pkg.sv | 35 +++
 rtl/ps2_line_filter.sv | 29 ++
 rtl/ps2_device_transceiver.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_ps2_device_transceiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_dev_pkg.sv
// Shared types and constants for the PS/2 device-side transceiver.
// FSM state enum, frame sizes, error codes, ack byte, parity helper.
package ps2_dev_pkg;

  typedef enum logic [3:0] {
    IDLE,
    TX_WAIT,
    TX_BIT_HI,
    TX_BIT_LO,
    RX_WAIT_REL,
    RX_BIT_LO,
    RX_BIT_HI,
    RX_ACK_LO,
    RX_ACK_HI,
    DONE_GAP
  } ps2State_t;

  localparam int TX_FRAME_BITS = 11;
  localparam int RX_FRAME_BITS = 10;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_STOP   = 2'b10;

  localparam logic [7:0] PS2_ACK_BYTE = 8'hFA;

  // Filtered lines lag the pins by ~11 cycles; after releasing
  // the clock, a low clk_s is only trusted past this many cycles.
  localparam int FILT_LAT = 16;

  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus 8-sample agreement filter for one line.
// Ports: CLK, RESET, lineRaw (pin level), lineFilt (filtered level).
module ps2_line_filter (
  input  logic CLK,
  input  logic RESET,
  input  logic lineRaw,
  output logic lineFilt
);

  logic [1:0] sync;
  logic [7:0] hist;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync     <= 2'b11;
      hist     <= 8'hFF;
      lineFilt <= 1'b1;
    end else begin
      sync <= {sync[0], lineRaw};
      hist <= {hist[6:0], sync[1]};
      if (&hist) begin
        lineFilt <= 1'b1;
      end else if (~|hist) begin
        lineFilt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_device_transceiver.sv
// Device-side (mouse-end) PS/2 transceiver: drives the PS/2 clock,
// sends device frames, receives host command frames, open-drain.
// Ports: CLK, RESET (sync, active high), CLK/DATA_MOUSE_IN (pins),
// CLK/DATA_MOUSE_OUT_EN (1 = pull low), SEND_BYTE/BYTE_TO_SEND/READY
// (one-deep TX slot), BYTE_SENT, BYTE_READY/BYTE_READ/BYTE_ERROR.
// Macro PS2_DEV_AUTO_ACK_EN: queue 8'hFA after each clean RX byte.
module ps2_device_transceiver
  import ps2_dev_pkg::*;
#(
  parameter int CLK_HALF    = 4000,
  parameter int INHIBIT_MIN = 10000,
  parameter int IDLE_MIN    = 5000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       READY,
  output logic       BYTE_SENT,
  output logic       BYTE_READY,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR
);

  localparam int PW = $clog2(CLK_HALF + 1);
  localparam int HW = $clog2(INHIBIT_MIN + 1);
  localparam int IW = $clog2(IDLE_MIN + 1);

  localparam logic [PW-1:0] HALF_END = PW'(CLK_HALF - 1);
  localparam logic [PW-1:0] HALF_MID = PW'(CLK_HALF / 2);
  localparam logic [PW-1:0] GUARD    = PW'(FILT_LAT);
  localparam logic [HW-1:0] HOLD_END = HW'(INHIBIT_MIN);
  localparam logic [IW-1:0] IDLE_END = IW'(IDLE_MIN);
  localparam logic [3:0]    TX_LAST  = 4'(TX_FRAME_BITS);
  localparam logic [3:0]    RX_LAST  = 4'(RX_FRAME_BITS - 1);

  logic clkS;
  logic dataS;

  ps2_line_filter uClkFilt (
    .CLK      (CLK),
    .RESET    (RESET),
    .lineRaw  (CLK_MOUSE_IN),
    .lineFilt (clkS)
  );

  ps2_line_filter uDataFilt (
    .CLK      (CLK),
    .RESET    (RESET),
    .lineRaw  (DATA_MOUSE_IN),
    .lineFilt (dataS)
  );

  ps2State_t     state, stateN;
  logic [PW-1:0] phaseCnt, phaseN;
  logic [3:0]    bitCnt, bitN;
  logic [10:0]   txShift, txN;
  logic [9:0]    rxShift, rxN;
  logic          slotFull, slotFullN;
  logic [7:0]    slotByte, slotByteN;
  logic          clkEn, clkEnN;
  logic          dataEn, dataEnN;
  logic          sent, sentN;
  logic          rdy, rdyN;
  logic [7:0]    byteRead, byteReadN;
  logic [1:0]    byteErr, byteErrN;
  logic          hostHeld, hostHeldN;
  logic [HW-1:0] holdCnt;
  logic [IW-1:0] idleCnt;

  logic       phaseEnd;
  logic       heldNow;
  logic       idleDone;
  logic [1:0] rxErr;

  assign phaseEnd = (phaseCnt == HALF_END);
  assign heldNow  = (holdCnt == HOLD_END);
  assign idleDone = (idleCnt == IDLE_END);

  assign rxErr =
    (rxShift[9] ? ERR_NONE : ERR_STOP) |
    ((rxShift[8] != oddParity(rxShift[7:0])) ? ERR_PARITY : ERR_NONE);

  // Host hold timer runs only while the host, not we, holds clock low.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      holdCnt <= '0;
      idleCnt <= '0;
    end else begin
      if (!clkS && !clkEn) begin
        if (!heldNow) holdCnt <= holdCnt + 1'b1;
      end else begin
        holdCnt <= '0;
      end
      if (clkS && dataS) begin
        if (!idleDone) idleCnt <= idleCnt + 1'b1;
      end else begin
        idleCnt <= '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      phaseCnt <= '0;
      bitCnt   <= '0;
      txShift  <= '0;
      rxShift  <= '0;
      slotFull <= 1'b0;
      slotByte <= '0;
      clkEn    <= 1'b0;
      dataEn   <= 1'b0;
      sent     <= 1'b0;
      rdy      <= 1'b0;
      byteRead <= '0;
      byteErr  <= ERR_NONE;
      hostHeld <= 1'b0;
    end else begin
      state    <= stateN;
      phaseCnt <= phaseN;
      bitCnt   <= bitN;
      txShift  <= txN;
      rxShift  <= rxN;
      slotFull <= slotFullN;
      slotByte <= slotByteN;
      clkEn    <= clkEnN;
      dataEn   <= dataEnN;
      sent     <= sentN;
      rdy      <= rdyN;
      byteRead <= byteReadN;
      byteErr  <= byteErrN;
      hostHeld <= hostHeldN;
    end
  end

  always_comb begin
    stateN    = state;
    phaseN    = phaseCnt;
    bitN      = bitCnt;
    txN       = txShift;
    rxN       = rxShift;
    slotFullN = slotFull;
    slotByteN = slotByte;
    clkEnN    = clkEn;
    dataEnN   = dataEn;
    sentN     = 1'b0;
    rdyN      = 1'b0;
    byteReadN = byteRead;
    byteErrN  = byteErr;
    hostHeldN = hostHeld | heldNow;

    if (SEND_BYTE && !slotFull) begin
      slotFullN = 1'b1;
      slotByteN = BYTE_TO_SEND;
    end

    unique case (state)
      IDLE: begin
        clkEnN  = 1'b0;
        dataEnN = 1'b0;
        phaseN  = '0;
        bitN    = '0;
        // Clock release after a long hold: RTS if data low,
        // otherwise just the end of an inhibit.
        if (hostHeld && clkS) begin
          hostHeldN = 1'b0;
          if (!dataS) stateN = RX_WAIT_REL;
        end else if (slotFull && idleDone && !hostHeld) begin
          stateN = TX_WAIT;
        end
      end

      TX_WAIT: begin
        txN = {1'b1, oddParity(slotByte), slotByte, 1'b0};
        stateN = TX_BIT_HI;
      end

      TX_BIT_HI: begin
        phaseN = phaseCnt + 1'b1;
        if (bitCnt != TX_LAST && phaseCnt >= GUARD && !clkS) begin
          // Host grabbed the clock: abort, frame stays queued.
          clkEnN  = 1'b0;
          dataEnN = 1'b0;
          phaseN  = '0;
          stateN  = IDLE;
        end else if (phaseEnd) begin
          phaseN = '0;
          if (bitCnt == TX_LAST) begin
            dataEnN   = 1'b0;
            sentN     = 1'b1;
            slotFullN = 1'b0;
            stateN    = DONE_GAP;
          end else begin
            clkEnN = 1'b1;
            stateN = TX_BIT_LO;
          end
        end else if (phaseCnt == HALF_MID && bitCnt != TX_LAST) begin
          dataEnN = ~txShift[0];
        end
      end

      TX_BIT_LO: begin
        phaseN = phaseCnt + 1'b1;
        if (phaseEnd) begin
          phaseN = '0;
          clkEnN = 1'b0;
          txN    = {1'b0, txShift[10:1]};
          bitN   = bitCnt + 1'b1;
          stateN = TX_BIT_HI;
        end
      end

      RX_WAIT_REL: begin
        if (clkS) begin
          clkEnN = 1'b1;
          phaseN = '0;
          bitN   = '0;
          stateN = RX_BIT_LO;
        end
      end

      RX_BIT_LO: begin
        phaseN = phaseCnt + 1'b1;
        if (phaseEnd) begin
          phaseN = '0;
          rxN    = {dataS, rxShift[9:1]};
          clkEnN = 1'b0;
          stateN = RX_BIT_HI;
        end
      end

      RX_BIT_HI: begin
        phaseN = phaseCnt + 1'b1;
        if (phaseCnt >= GUARD && !clkS) begin
          clkEnN  = 1'b0;
          dataEnN = 1'b0;
          phaseN  = '0;
          stateN  = IDLE;
        end else if (phaseEnd) begin
          phaseN = '0;
          if (bitCnt == RX_LAST) begin
            dataEnN = 1'b1;
            stateN  = RX_ACK_HI;
          end else begin
            bitN   = bitCnt + 1'b1;
            clkEnN = 1'b1;
            stateN = RX_BIT_LO;
          end
        end
      end

      RX_ACK_HI: begin
        phaseN = phaseCnt + 1'b1;
        if (phaseEnd) begin
          phaseN = '0;
          clkEnN = 1'b1;
          stateN = RX_ACK_LO;
        end
      end

      RX_ACK_LO: begin
        phaseN = phaseCnt + 1'b1;
        if (phaseEnd) begin
          phaseN    = '0;
          clkEnN    = 1'b0;
          dataEnN   = 1'b0;
          rdyN      = 1'b1;
          byteReadN = rxShift[7:0];
          byteErrN  = rxErr;
`ifdef PS2_DEV_AUTO_ACK_EN
          if (rxErr == ERR_NONE) begin
            slotFullN = 1'b1;
            slotByteN = PS2_ACK_BYTE;
          end
`endif
          stateN = DONE_GAP;
        end
      end

      DONE_GAP: begin
        clkEnN  = 1'b0;
        dataEnN = 1'b0;
        phaseN  = phaseCnt + 1'b1;
        if (phaseEnd) begin
          phaseN = '0;
          stateN = IDLE;
        end
      end

      default: begin
        clkEnN  = 1'b0;
        dataEnN = 1'b0;
        stateN  = IDLE;
      end
    endcase
  end

  assign CLK_MOUSE_OUT_EN  = clkEn;
  assign DATA_MOUSE_OUT_EN = dataEn;
  assign READY             = !slotFull;
  assign BYTE_SENT         = sent;
  assign BYTE_READY        = rdy;
  assign BYTE_READ         = byteRead;
  assign BYTE_ERROR        = byteErr;

endmodule

// File: tb/tb_ps2_device_transceiver.sv
// Directed bench for ps2_device_transceiver with a host-side line model.
// Scaled timing: CLK_HALF=40, INHIBIT_MIN=100, IDLE_MIN=50.
module tb_ps2_device_transceiver;

  localparam int HALF = 40;
  localparam int INH  = 100;
  localparam int IDL  = 50;

  logic       CLK;
  logic       RESET;
  logic       CLK_MOUSE_OUT_EN;
  logic       DATA_MOUSE_OUT_EN;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       READY;
  logic       BYTE_SENT;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR;

  logic hostClkLow;
  logic hostDataLow;
  logic clkLine;
  logic dataLine;

  assign clkLine  = !(CLK_MOUSE_OUT_EN || hostClkLow);
  assign dataLine = !(DATA_MOUSE_OUT_EN || hostDataLow);

  int compared;
  int mismatched;
  int sentCount;
  int rdyCount;
  logic monPrev;
  logic txBits[$];

  ps2_device_transceiver #(
    .CLK_HALF    (HALF),
    .INHIBIT_MIN (INH),
    .IDLE_MIN    (IDL)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .CLK_MOUSE_IN      (clkLine),
    .DATA_MOUSE_IN     (dataLine),
    .CLK_MOUSE_OUT_EN  (CLK_MOUSE_OUT_EN),
    .DATA_MOUSE_OUT_EN (DATA_MOUSE_OUT_EN),
    .SEND_BYTE         (SEND_BYTE),
    .BYTE_TO_SEND      (BYTE_TO_SEND),
    .READY             (READY),
    .BYTE_SENT         (BYTE_SENT),
    .BYTE_READY        (BYTE_READY),
    .BYTE_READ         (BYTE_READ),
    .BYTE_ERROR        (BYTE_ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    monPrev   = 1'b0;
    sentCount = 0;
    rdyCount  = 0;
  end

  // Record the data line at every device clock falling edge.
  always @(negedge CLK) begin
    if (CLK_MOUSE_OUT_EN && !monPrev) txBits.push_back(dataLine);
    monPrev <= CLK_MOUSE_OUT_EN;
    if (BYTE_SENT)  sentCount <= sentCount + 1;
    if (BYTE_READY) rdyCount  <= rdyCount + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for the device clock enable to switch to 'tgt'.
  task automatic waitDevEdge(input logic tgt, output logic ok);
    logic prev;
    prev = CLK_MOUSE_OUT_EN;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (CLK_MOUSE_OUT_EN === tgt && prev !== tgt) begin
        ok = 1'b1;
        break;
      end
      prev = CLK_MOUSE_OUT_EN;
    end
  endtask

  task automatic pulseSend(input logic [7:0] b);
    SEND_BYTE    = 1'b1;
    BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE = 1'b0;
  endtask

  task automatic waitSent(input string tag, input logic [10:0] exp);
    logic ok;
    logic [10:0] got;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (BYTE_SENT) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_sent"}, ok, 1);
    check({tag, "_nbits"}, txBits.size(), 11);
    got = '0;
    for (int i = 0; i < 11 && i < txBits.size(); i++) got[i] = txBits[i];
    check({tag, "_frame"}, got, exp);
    check({tag, "_ready"}, READY, 1);
  endtask

  task automatic hostSend(input logic [7:0] b, input logic par,
                          input logic stp, input logic withSend,
                          input logic [7:0] sb, input logic [7:0] expB,
                          input logic [1:0] expE, input string tag);
    logic [9:0] bits;
    logic ok;
    int rdyBefore;
    bits = {stp, par, b};
    rdyBefore = rdyCount;
    hostClkLow = 1'b1;
    repeat (INH + 30) @(negedge CLK);
    hostDataLow = 1'b1;
    repeat (5) @(negedge CLK);
    hostClkLow = 1'b0;
    if (withSend) begin
      // Lands on the cycle the filtered release reaches the FSM.
      repeat (11) @(negedge CLK);
      pulseSend(sb);
    end
    for (int i = 0; i < 10; i++) begin
      waitDevEdge(1'b1, ok);
      check({tag, "_fall"}, ok, 1);
      if (!ok) return;
      hostDataLow = !bits[i];
    end
    waitDevEdge(1'b0, ok);
    check({tag, "_rise"}, ok, 1);
    hostDataLow = 1'b0;
    waitDevEdge(1'b1, ok);
    check({tag, "_ackfall"}, ok, 1);
    check({tag, "_ackdata"}, DATA_MOUSE_OUT_EN, 1);
    ok = 1'b0;
    for (int i = 0; i < 4 * HALF; i++) begin
      @(negedge CLK);
      if (BYTE_READY) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_rdy"}, ok, 1);
    check({tag, "_byte"}, BYTE_READ, expB);
    check({tag, "_err"}, BYTE_ERROR, expE);
    check({tag, "_rel"}, DATA_MOUSE_OUT_EN, 0);
    repeat (HALF + 20) @(negedge CLK);
    check({tag, "_rdycnt"}, rdyCount, rdyBefore + 1);
  endtask

  initial begin
    logic ok;
    int sentBefore;
    int rdyBefore;
    logic [10:0] exp5;
    compared     = 0;
    mismatched   = 0;
    hostClkLow   = 1'b0;
    hostDataLow  = 1'b0;
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = 8'h00;
    RESET        = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_clken", CLK_MOUSE_OUT_EN, 0);
    check("rst_dataen", DATA_MOUSE_OUT_EN, 0);
    check("rst_ready", READY, 1);
    check("rst_sent", BYTE_SENT, 0);
    check("rst_brdy", BYTE_READY, 0);
    check("rst_bread", BYTE_READ, 8'h00);
    check("rst_berr", BYTE_ERROR, 2'b00);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);

    // 1: plain transmit of FA; second request while busy is dropped
    sentBefore = sentCount;
    txBits.delete();
    pulseSend(8'hFA);
    check("t1_busy", READY, 0);
    pulseSend(8'h11);
    waitSent("t1", 11'b1_1_11111010_0);
    repeat (100) @(negedge CLK);
    check("t1_sentcnt", sentCount, sentBefore + 1);
    check("t1_noextra", txBits.size(), 11);

    // 2: host command F4, good parity
    hostSend(8'hF4, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF4, 2'b00, "t2");
    repeat (50) @(negedge CLK);

    // 3: parity error, then stop-bit error
    hostSend(8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 2'b01, "t3p");
    repeat (50) @(negedge CLK);
    hostSend(8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 2'b10, "t3s");
    repeat (50) @(negedge CLK);

    // 4: host inhibits after the 5th falling edge of a 55 frame
    sentBefore = sentCount;
    txBits.delete();
    pulseSend(8'h55);
    for (int i = 0; i < 5; i++) begin
      waitDevEdge(1'b1, ok);
      check("t4_fall", ok, 1);
    end
    repeat (5) @(negedge CLK);
    hostClkLow = 1'b1;
    repeat (100) @(negedge CLK);
    check("t4_relclk", CLK_MOUSE_OUT_EN, 0);
    check("t4_reldata", DATA_MOUSE_OUT_EN, 0);
    repeat (20) @(negedge CLK);
    hostClkLow = 1'b0;
    txBits.delete();
    check("t4_nosent", sentCount, sentBefore);
    check("t4_pending", READY, 0);
    waitSent("t4", 11'b1_1_01010101_0);
    repeat (100) @(negedge CLK);
    check("t4_sentcnt", sentCount, sentBefore + 1);

    // 5: SEND_BYTE 08 collides with an RTS for E8
    sentBefore = sentCount;
    hostSend(8'hE8, 1'b1, 1'b1, 1'b1, 8'h08, 8'hE8, 2'b00, "t5");
    check("t5_pending", READY, 0);
    txBits.delete();
`ifdef PS2_DEV_AUTO_ACK_EN
    exp5 = 11'b1_1_11111010_0;
`else
    exp5 = 11'b1_0_00001000_0;
`endif
    waitSent("t5", exp5);
    repeat (100) @(negedge CLK);
    check("t5_sentcnt", sentCount, sentBefore + 1);

    // 6: reset in the middle of receiving, then a clean F3
    rdyBefore = rdyCount;
    hostClkLow = 1'b1;
    repeat (INH + 30) @(negedge CLK);
    hostDataLow = 1'b1;
    repeat (5) @(negedge CLK);
    hostClkLow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      waitDevEdge(1'b1, ok);
      check("t6_fall", ok, 1);
      hostDataLow = (i == 2 || i == 3);
    end
    repeat (10) @(negedge CLK);
    RESET = 1'b1;
    hostDataLow = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    check("t6_clken", CLK_MOUSE_OUT_EN, 0);
    check("t6_dataen", DATA_MOUSE_OUT_EN, 0);
    check("t6_ready", READY, 1);
    check("t6_bread", BYTE_READ, 8'h00);
    repeat (300) @(negedge CLK);
    check("t6_nordy", rdyCount, rdyBefore);
    hostSend(8'hF3, 1'b1, 1'b1, 1'b0, 8'h00, 8'hF3, 2'b00, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
